// File: rtl/mul_div_pkg.sv
// rtl/mul_div_pkg.sv - op encodings, FSM states and sizing helper for mul_div_unit
package mul_div_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mul_div_sign_fix.sv
// rtl/mul_div_sign_fix.sv - conditional two's-complement negation
// Used both to take operand magnitudes and to restore result signs.
module mul_div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? ('0 - value) : value;

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO (WIDTH >= 4)
// Optional MUL_DIV_EARLY_EXIT_EN: multiply stops once remaining multiplier bits are zero.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      count;
  logic               is_div, sign_q, sign_r, dbz;
  logic [2*WIDTH-1:0] mcand, prod, prod_fix;
  logic [WIDTH-1:0]   mplier, divisor, quo, rem;
  logic [WIDTH-1:0]   quo_fix, rem_fix, mag_a, mag_b, rem_sub;
  logic [WIDTH:0]     rem_shift;
  logic               op_div, op_signed, b_zero, neg_a, neg_b, rem_ge, last_iter;

  assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign b_zero    = (op_b == '0);
  // A zero divisor keeps the raw dividend so the remainder comes back as op_a untouched.
  assign neg_a     = op_signed && op_a[WIDTH-1] && !(op_div && b_zero);
  assign neg_b     = op_signed && op_b[WIDTH-1];

  mul_div_sign_fix #(.WIDTH(WIDTH)) u_mag_a (.value(op_a), .negate(neg_a), .result(mag_a));
  mul_div_sign_fix #(.WIDTH(WIDTH)) u_mag_b (.value(op_b), .negate(neg_b), .result(mag_b));
  mul_div_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (.value(prod), .negate(sign_q), .result(prod_fix));
  mul_div_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (.value(quo), .negate(sign_q), .result(quo_fix));
  mul_div_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (.value(rem), .negate(sign_r), .result(rem_fix));

  assign rem_shift = {rem, quo[WIDTH-1]};
  assign rem_ge    = (rem_shift >= {1'b0, divisor});
  assign rem_sub   = rem_shift[WIDTH-1:0] - divisor;

`ifdef MUL_DIV_EARLY_EXIT_EN
  assign last_iter = (count == LAST_ITER) || (!is_div && (mplier[WIDTH-1:1] == '0));
`else
  assign last_iter = (count == LAST_ITER);
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      is_div      <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dbz         <= 1'b0;
      mcand       <= '0;
      prod        <= '0;
      mplier      <= '0;
      divisor     <= '0;
      quo         <= '0;
      rem         <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_hi) hi <= wr_data;
          if (wr_lo) lo <= wr_data;
          if (start) begin
            state   <= RUN;
            count   <= '0;
            is_div  <= op_div;
            sign_q  <= neg_a ^ neg_b;
            sign_r  <= neg_a;
            dbz     <= op_div && b_zero;
            mcand   <= {{WIDTH{1'b0}}, mag_a};
            prod    <= '0;
            mplier  <= mag_b;
            divisor <= mag_b;
            quo     <= mag_a;
            rem     <= '0;
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            count <= count + CW'(1);
            if (is_div) begin
              quo <= {quo[WIDTH-2:0], rem_ge};
              rem <= rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
            end else begin
              if (mplier[0]) prod <= prod + mcand;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
            end
            if (last_iter) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!flush) begin
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
            done        <= 1'b1;
            div_by_zero <= dbz;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit against an arithmetic model
module tb_mul_div_unit;

  localparam int W = 32;
`ifdef MUL_DIV_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic          clock, reset, start, flush, wr_hi, wr_lo;
  logic [1:0]    op;
  logic [W-1:0]  op_a, op_b, wr_data;
  logic [W-1:0]  hi, lo;
  logic          busy, done, div_by_zero;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  int            m_left;
  logic [W-1:0]  m_hi, m_lo, p_hi, p_lo;
  bit            m_done, m_dbz, p_dbz;

  mul_div_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .flush(flush), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, straight from the instruction definitions.
  function automatic void model_result(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                       output logic [W-1:0] rh, output logic [W-1:0] rl,
                                       output bit rd, output int lat);
    longint sa, sb, p;
    longint unsigned ua, ub, up;
    logic [W-1:0] mag;
    int bl;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    rd = 1'b0;
    lat = W + 1;
    rh = '0;
    rl = '0;
    case (o)
      2'b00: begin p = sa * sb; {rh, rl} = p; end
      2'b01: begin up = ua * ub; {rh, rl} = up; end
      2'b10: begin
        if (b == '0) begin rl = '1; rh = a; rd = 1'b1; end
        else begin p = sa / sb; rl = p[W-1:0]; p = sa % sb; rh = p[W-1:0]; end
      end
      default: begin
        if (b == '0) begin rl = '1; rh = a; rd = 1'b1; end
        else begin up = ua / ub; rl = up[W-1:0]; up = ua % ub; rh = up[W-1:0]; end
      end
    endcase
    if (EE && !o[1]) begin
      mag = (o == 2'b00 && b[W-1]) ? (32'd0 - b) : b;
      bl = 0;
      for (int i = 0; i < W; i++) if (mag[i]) bl = i + 1;
      lat = ((bl < 1) ? 1 : bl) + 1;
    end
  endfunction

  always @(posedge clock or negedge reset) begin : model
    logic [W-1:0] rh, rl;
    bit rd;
    int rlat;
    if (!reset) begin
      m_left <= 0; m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_dbz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      if (m_left != 0) begin
        if (flush) m_left <= 0;
        else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_hi <= p_hi; m_lo <= p_lo; m_done <= 1'b1; m_dbz <= p_dbz;
          end
        end
      end else begin
        if (wr_hi) m_hi <= wr_data;
        if (wr_lo) m_lo <= wr_data;
        if (start) begin
          model_result(op, op_a, op_b, rh, rl, rd, rlat);
          p_hi <= rh; p_lo <= rl; p_dbz <= rd; m_left <= rlat;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
      check("busy", 64'(busy), 64'(m_left != 0));
      check("done", 64'(done), 64'(m_done));
      check("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
    end
  end

  task automatic pulse_start(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    op = o; op_a = a; op_b = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic run_lit(input string name, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input bit ed, input int elat);
    int n, nb;
    pulse_start(o, a, b);
    nb = busy ? 1 : 0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clock);
      n++;
      if (busy) nb++;
    end
    check({name, " latency"}, 64'(n), 64'(elat));
    check({name, " busy cycles"}, 64'(nb), 64'(elat));
    check({name, " hi"}, 64'(hi), 64'(eh));
    check({name, " lo"}, 64'(lo), 64'(el));
    check({name, " div_by_zero"}, 64'(div_by_zero), 64'(ed));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin : main
    logic [W-1:0] rh, rl;
    bit rd;
    int lat, n, nd;
    reset = 1'b0; start = 1'b0; flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = '0; op_a = '0; op_b = '0; wr_data = '0;

    model_result(2'b10, 32'hFFFF_FFF9, 32'd2, rh, rl, rd, lat);
    check("model DIV -7/2 lo", 64'(rl), 64'h0000_0000_FFFF_FFFD);
    check("model DIV -7/2 hi", 64'(rh), 64'h0000_0000_FFFF_FFFF);
    model_result(2'b00, 32'hFFFF_FFFD, 32'd7, rh, rl, rd, lat);
    check("model MULT -3*7 lo", 64'(rl), 64'h0000_0000_FFFF_FFEB);

    repeat (2) @(negedge clock);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset div_by_zero", 64'(div_by_zero), 64'd0);
    reset = 1'b1;
    chk_en = 1'b1;

    run_lit("MULTU max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33);
    run_lit("MULT -3*7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, EE ? 4 : 33);
    run_lit("DIV -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    run_lit("DIVU 7/0", 2'b11, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1, 33);
    run_lit("DIV MIN/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33);
    run_lit("DIV -9/0", 2'b10, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1, 33);

    // Second start and MTHI while busy must both be ignored.
    pulse_start(2'b11, 32'd1000, 32'd7);
    repeat (4) @(negedge clock);
    start = 1'b1; op = 2'b01; op_a = 32'd9; op_b = 32'd9;
    @(negedge clock);
    start = 1'b0; wr_hi = 1'b1; wr_data = 32'h1234;
    @(negedge clock);
    wr_hi = 1'b0;
    wait_done(n);
    check("ignored start done seen", 64'(done), 64'd1);
    check("ignored start hi", 64'(hi), 64'd6);
    check("ignored start lo", 64'(lo), 64'd142);
    nd = 0;
    repeat (50) begin @(negedge clock); if (done) nd++; end
    check("ignored start extra done", 64'(nd), 64'd0);

    @(negedge clock);
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h5A5A;
    @(negedge clock);
    wr_hi = 1'b0; wr_lo = 1'b0;
    check("both writes hi", 64'(hi), 64'h5A5A);
    check("both writes lo", 64'(lo), 64'h5A5A);
    wr_hi = 1'b1; wr_data = 32'hAAAA;
    @(negedge clock);
    wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h5555;
    @(negedge clock);
    wr_lo = 1'b0;
    check("MTHI hi", 64'(hi), 64'hAAAA);
    check("MTLO lo", 64'(lo), 64'h5555);

    pulse_start(2'b00, 32'd123, 32'hFFFF_FE38);
    repeat (9) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush hi kept", 64'(hi), 64'hAAAA);
    check("flush lo kept", 64'(lo), 64'h5555);
    nd = 0;
    repeat (40) begin @(negedge clock); if (done) nd++; end
    check("flush no done", 64'(nd), 64'd0);

    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("idle flush busy", 64'(busy), 64'd0);

    @(negedge clock);
    start = 1'b1; op = 2'b01; op_a = 32'd2; op_b = 32'd3; wr_lo = 1'b1; wr_data = 32'd77;
    @(negedge clock);
    start = 1'b0; wr_lo = 1'b0;
    check("start+MTLO lo", 64'(lo), 64'd77);
    wait_done(n);
    check("start+MTLO result lo", 64'(lo), 64'd6);

    pulse_start(2'b11, 32'd100, 32'd9);
    wait_done(n);
    check("b2b first lo", 64'(lo), 64'd11);
    check("b2b first hi", 64'(hi), 64'd1);
    start = 1'b1; op = 2'b00; op_a = 32'd6; op_b = 32'hFFFF_FFF9;
    @(negedge clock);
    start = 1'b0;
    wait_done(n);
    check("b2b second latency", 64'(n), 64'(EE ? 4 : 33));
    check("b2b second lo", 64'(lo), 64'hFFFF_FFD6);
    check("b2b second hi", 64'(hi), 64'hFFFF_FFFF);

    run_lit("MULTU 5*3", 2'b01, 32'd5, 32'd3, 32'd0, 32'd15, 1'b0, EE ? 3 : 33);
    run_lit("MULTU x*0", 2'b01, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0, EE ? 2 : 33);

    nd = 0;
    repeat (4000) begin
      @(negedge clock);
      if (done) nd++;
      start = ($urandom_range(0, 9) == 0);
      op = 2'($urandom);
      op_a = pick();
      op_b = pick();
      flush = ($urandom_range(0, 79) == 0);
      wr_hi = ($urandom_range(0, 11) == 0);
      wr_lo = ($urandom_range(0, 11) == 0);
      wr_data = $urandom;
    end
    @(negedge clock);
    start = 1'b0; flush = 1'b1; wr_hi = 1'b0; wr_lo = 1'b0;
    @(negedge clock);
    flush = 1'b0;
    check("random ops completed", 64'(nd > 20), 64'd1);

    @(negedge clock);
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hDEAD;
    @(negedge clock);
    wr_hi = 1'b0; wr_lo = 1'b0;
    pulse_start(2'b01, 32'hFFFF, 32'hFFFF);
    repeat (5) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("async reset hi", 64'(hi), 64'd0);
    check("async reset lo", 64'(lo), 64'd0);
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset done", 64'(done), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
